// File: rtl/approx_err_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
// Widths here follow the default operand width of the monitor.
package approx_err_pkg;

  localparam int W  = 8;
  localparam int PW = 2 * W;
  localparam int DW = 2 * W + 1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [PW-1:0] mag;
    logic          neg;
  } abs_t;

  // Magnitude of (exact - apprx); neg set when apprx overshoots.
  function automatic abs_t abs_diff(
    input logic [PW-1:0] exact,
    input logic [PW-1:0] apprx
  );
    abs_t r;
    r.neg = (exact < apprx);
    r.mag = r.neg ? (apprx - exact) : (exact - apprx);
    return r;
  endfunction

endpackage

// File: rtl/approx_mul_err_monitor_err_stage.sv
// S1/S2 datapath: operand capture, exact product, error distance.
// The valid pipe is flushed by clear so in-flight samples are dropped.
module err_stage
  import approx_err_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic [PW-1:0]        p_apprx,
  output logic                 v2,
  output logic signed [DW-1:0] diff,
  output logic [PW-1:0]        abs_d,
  output logic                 neq
);

  logic          v1;
  logic [W-1:0]  a1;
  logic [W-1:0]  b1;
  logic [PW-1:0] p1;
  logic [PW-1:0] exact;
  abs_t          ad;

  assign exact = PW'(a1) * PW'(b1);
  assign ad    = abs_diff(exact, p1);

  // S1: capture the accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      p1 <= '0;
    end else if (clear) begin
      v1 <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1 <= a;
        b1 <= b;
        p1 <= p_apprx;
      end
    end
  end

  // S2: register signed distance, magnitude and mismatch flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      diff  <= '0;
      abs_d <= '0;
      neq   <= 1'b0;
    end else if (clear) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        diff  <= ad.neg ? -{1'b0, ad.mag}
                        :  {1'b0, ad.mag};
        abs_d <= ad.mag;
        neq   <= |ad.mag;
      end
    end
  end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Error-statistics monitor for an approximate multiplier stream.
// Accepts NUM_SAMPLES samples, drains the pipe, then freezes results.
module approx_mul_err_monitor
  import approx_err_pkg::*;
#(
  parameter int W           = 8,
  parameter int NUM_SAMPLES = 10000,
  parameter int CNT_W       = 14,
  parameter int SUM_W       = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [2*W-1:0]     p_apprx,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [SUM_W:0]     sum_ed,
  output logic [SUM_W-1:0]   sum_ed_abs,
  output logic [2*W-1:0]     max_ed_abs,
  output logic               done
);

  state_t              state;
  logic [CNT_W-1:0]    acc_cnt;
  logic                accept;
  logic                v2;
  logic signed [DW-1:0] diff;
  logic [PW-1:0]       abs_d;
  logic                neq;

  assign in_ready = (state == RUN) && !clear;
  assign accept   = in_valid && in_ready;

  err_stage #(.W(W)) u_err (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .accept  (accept),
    .a       (a),
    .b       (b),
    .p_apprx (p_apprx),
    .v2      (v2),
    .diff    (diff),
    .abs_d   (abs_d),
    .neq     (neq)
  );

  // Run/drain/done sequencing and accepted-sample count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      acc_cnt <= '0;
      done    <= 1'b0;
    end else if (clear) begin
      state   <= RUN;
      acc_cnt <= '0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt == CNT_W'(NUM_SAMPLES - 1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (v2 && sample_cnt == CNT_W'(NUM_SAMPLES - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // S3: fold each retired sample into the statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      sum_ed_abs <= '0;
      max_ed_abs <= '0;
    end else if (clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed     <= '0;
      sum_ed_abs <= '0;
      max_ed_abs <= '0;
    end else if (v2) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      err_cnt    <= err_cnt + CNT_W'(neq);
      sum_ed     <= sum_ed
                  + {{(SUM_W + 1 - DW){diff[DW-1]}}, diff};
      sum_ed_abs <= sum_ed_abs
                  + {{(SUM_W - PW){1'b0}}, abs_d};
      if (abs_d > max_ed_abs)
        max_ed_abs <= abs_d;
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Bench for approx_mul_err_monitor: default-size instance plus a
// NUM_SAMPLES=4 instance for the fill/drain/done boundary.
module tb_approx_mul_err_monitor;

  logic        clk;
  logic        rst;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] p;
  logic        v_big, v_small, clr_big, clr_small;

  logic        b_ready, b_done, s_ready, s_done;
  logic [13:0] b_cnt, b_err, s_cnt, s_err;
  logic [30:0] b_sum, s_sum;
  logic [29:0] b_abs, s_abs;
  logic [15:0] b_max, s_max;

  approx_mul_err_monitor u_big (
    .clk(clk), .rst(rst), .clear(clr_big),
    .in_valid(v_big), .in_ready(b_ready),
    .a(a), .b(b), .p_apprx(p),
    .sample_cnt(b_cnt), .err_cnt(b_err),
    .sum_ed(b_sum), .sum_ed_abs(b_abs),
    .max_ed_abs(b_max), .done(b_done)
  );

  approx_mul_err_monitor #(.NUM_SAMPLES(4)) u_small (
    .clk(clk), .rst(rst), .clear(clr_small),
    .in_valid(v_small), .in_ready(s_ready),
    .a(a), .b(b), .p_apprx(p),
    .sample_cnt(s_cnt), .err_cnt(s_err),
    .sum_ed(s_sum), .sum_ed_abs(s_abs),
    .max_ed_abs(s_max), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     due;
    longint cnt, err, sum, sabs, mx;
  } exp_t;

  exp_t   q[$];
  longint m_cnt, m_err, m_sum, m_abs, m_max;
  int     passes = 0;
  int     fails  = 0;
  int     total  = 0;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_sum = 0; m_abs = 0; m_max = 0;
    q.delete();
  endtask

  task automatic chk_big_zero(input string tag);
    chk({tag, "_cnt"}, b_cnt, 0);
    chk({tag, "_err"}, b_err, 0);
    chk({tag, "_sum"}, $signed(b_sum), 0);
    chk({tag, "_abs"}, b_abs, 0);
    chk({tag, "_max"}, b_max, 0);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    while (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("sb_cnt", b_cnt, e.cnt);
      chk("sb_err", b_err, e.err);
      chk("sb_sum", $signed(b_sum), e.sum);
      chk("sb_abs", b_abs, e.sabs);
      chk("sb_max", b_max, e.mx);
    end
  endtask

  task automatic drive(input int ia, input int ib, input int ip);
    exp_t   e;
    longint d;
    a = 8'(ia); b = 8'(ib); p = 16'(ip); v_big = 1'b1;
    d = longint'(ia * ib) - longint'(ip);
    m_cnt++;
    if (d != 0) m_err++;
    m_sum += d;
    m_abs += (d < 0) ? -d : d;
    if (((d < 0) ? -d : d) > m_max) m_max = (d < 0) ? -d : d;
    e.due = cyc + 3;
    e.cnt = m_cnt; e.err = m_err; e.sum = m_sum;
    e.sabs = m_abs; e.mx = m_max;
    q.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    v_big = 1'b0;
    v_small = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_big();
    v_big = 1'b0;
    clr_big = 1'b1;
    #1;
    chk("clr_ready_low", b_ready, 0);
    model_reset();
    tick();
    clr_big = 1'b0;
    chk_big_zero("clr");
  endtask

  initial begin
    int nerr;
    rst = 1'b1;
    a = 0; b = 0; p = 0;
    v_big = 0; v_small = 0; clr_big = 0; clr_small = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", b_ready, 1);
    chk("rst_done", b_done, 0);
    chk_big_zero("rst");
    chk("rst_s_ready", s_ready, 1);
    rst = 1'b0;
    tick();

    // exact sample, then low approximation
    drive(3, 5, 15);
    idle(3);
    chk("exact_err", b_err, 0);
    drive(255, 255, 65024);
    idle(3);
    chk("low_sum", $signed(b_sum), 1);

    // high approximation then a larger low one
    clear_big();
    drive(2, 2, 6);
    idle(3);
    chk("high_sum", $signed(b_sum), -2);
    drive(10, 10, 96);
    idle(3);
    chk("mix_max", b_max, 4);

    // tie on max keeps value; back-to-back throughput
    drive(5, 5, 21);
    drive(6, 6, 34);
    drive(1, 1, 1);
    idle(3);

    // clear with two samples in flight
    drive(7, 7, 40);
    drive(9, 9, 80);
    a = 1; b = 1; p = 0;
    v_big = 1'b1;
    clr_big = 1'b1;
    #1;
    chk("clr_if_ready", b_ready, 0);
    model_reset();
    tick();
    clr_big = 1'b0;
    v_big = 1'b0;
    chk_big_zero("clr_if");
    idle(3);
    chk_big_zero("clr_late");
    chk("clr_ready_back", b_ready, 1);

    // NUM_SAMPLES=4 with in_valid high for 6 cycles
    for (int i = 0; i < 6; i++) begin
      a = 8'(i + 1); b = 2; p = 16'(2 * (i + 1) - 1);
      v_small = 1'b1;
      tick();
      chk("s_ready", s_ready, (i <= 2) ? 1 : 0);
      chk("s_done", s_done, (i == 5) ? 1 : 0);
    end
    chk("s_cnt4", s_cnt, 4);
    repeat (2) tick();
    v_small = 1'b0;
    chk("s_hold_cnt", s_cnt, 4);
    chk("s_hold_err", s_err, 4);
    chk("s_hold_sum", $signed(s_sum), 4);
    chk("s_hold_abs", s_abs, 4);
    chk("s_hold_max", s_max, 1);
    chk("s_hold_done", s_done, 1);
    chk("s_hold_ready", s_ready, 0);

    // clear small, refill, async reset mid-drain
    clr_small = 1'b1;
    tick();
    clr_small = 1'b0;
    chk("s_clr_cnt", s_cnt, 0);
    chk("s_clr_done", s_done, 0);
    for (int i = 0; i < 4; i++) begin
      a = 8'(i + 2); b = 3; p = 16'(3 * (i + 2) + 1);
      v_small = 1'b1;
      tick();
    end
    v_small = 1'b0;
    chk("s_drain_cnt", s_cnt, 2);
    chk("s_drain_sum", $signed(s_sum), -2);
    chk("s_drain_ready", s_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_cnt", s_cnt, 0);
    chk("arst_sum", $signed(s_sum), 0);
    chk("arst_max", s_max, 0);
    chk("arst_ready", s_ready, 1);
    chk("arst_done", s_done, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();

    // random regression over the full default sample count
    nerr = 0;
    for (int i = 0; i < 10000; i++) begin
      int ra, rb;
      ra = int'($urandom_range(0, 255));
      rb = int'($urandom_range(0, 255));
      if (((ra * rb) & 3) != 0) nerr++;
      drive(ra, rb, (ra * rb) & ~3);
    end
    idle(3);
    chk("rnd_done", b_done, 1);
    chk("rnd_ready", b_ready, 0);
    chk("rnd_cnt", b_cnt, 10000);
    chk("rnd_err", b_err, nerr);
    chk("rnd_max_le3", (b_max <= 16'd3) ? 1 : 0, 1);
    chk("rnd_sum_eq_abs", $signed(b_sum), b_abs);
    a = 0; b = 0; p = 0; v_big = 1'b1;
    repeat (3) tick();
    v_big = 1'b0;
    chk("rnd_hold_cnt", b_cnt, 10000);
    chk("sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
